// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch stage: MIPS field positions,
// opcode constants and the register index width.
package operand_fetch_pkg;

  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int REG_W  = 5;

  localparam logic [5:0] OP_RTYPE = 6'd0;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// One busy bit per architectural register, marking writes still in flight.
// Two combinational query ports serve the rs and rt lookups.
module reg_scoreboard
  import operand_fetch_pkg::*;
#(
  parameter int NREG = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clearAll,
  input  logic             setEn,
  input  logic [REG_W-1:0] setReg,
  input  logic             clrEn,
  input  logic [REG_W-1:0] clrReg,
  input  logic [REG_W-1:0] queryA,
  input  logic [REG_W-1:0] queryB,
  output logic             busyA,
  output logic             busyB
);

  logic [NREG-1:0] busy;

  // The set is written after the clear so a same-cycle set of the same register wins
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else if (clearAll) begin
      busy <= '0;
    end else begin
      if (clrEn) busy[clrReg] <= 1'b0;
      if (setEn) busy[setReg] <= 1'b1;
    end
  end

  assign busyA = busy[queryA];
  assign busyB = busy[queryB];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: decodes a MIPS instruction, reads/bypasses its sources,
// stalls on scoreboard hazards and presents a registered operand bundle.
module operand_fetch #(
  parameter int DATA_W = operand_fetch_pkg::DATA_W,
  parameter int NREG   = operand_fetch_pkg::NREG
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [31:0]                        in_instr,
  output logic [operand_fetch_pkg::REG_W-1:0] readReg1,
  output logic [operand_fetch_pkg::REG_W-1:0] readReg2,
  input  logic [DATA_W-1:0]                  readData1,
  input  logic [DATA_W-1:0]                  readData2,
  input  logic                               wb_valid,
  input  logic [operand_fetch_pkg::REG_W-1:0] wb_reg,
  input  logic [DATA_W-1:0]                  wb_data,
  input  logic                               flush,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [5:0]                         out_op,
  output logic [5:0]                         out_funct,
  output logic [DATA_W-1:0]                  out_opA,
  output logic [DATA_W-1:0]                  out_opB,
  output logic [operand_fetch_pkg::REG_W-1:0] out_dest,
  output logic [15:0]                        stall_count
);
  import operand_fetch_pkg::*;

  logic [5:0]       op;
  logic [5:0]       funct;
  logic [REG_W-1:0] rs;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;
  logic [15:0]      imm;
  logic             isRType;
  logic [REG_W-1:0] dest;
  logic             unusedShamt;

  assign op          = in_instr[OP_MSB:OP_LSB];
  assign rs          = in_instr[RS_MSB:RS_LSB];
  assign rt          = in_instr[RT_MSB:RT_LSB];
  assign rd          = in_instr[RD_MSB:RD_LSB];
  assign funct       = in_instr[FUNCT_MSB:FUNCT_LSB];
  assign imm         = in_instr[IMM_MSB:IMM_LSB];
  assign unusedShamt = ^in_instr[10:6];
  assign isRType     = (op == OP_RTYPE);
  assign dest        = isRType ? rd : rt;

  assign readReg1 = rs;
  assign readReg2 = rt;

  logic [DATA_W-1:0] rsVal;
  logic [DATA_W-1:0] rtVal;
  logic [DATA_W-1:0] opAVal;
  logic [DATA_W-1:0] opBVal;

  // Register 0 is hardwired to zero; a write landing this cycle overrides the file
  always_comb begin
    rsVal = readData1;
    rtVal = readData2;
    if (wb_valid && (wb_reg == rs)) rsVal = wb_data;
    if (wb_valid && (wb_reg == rt)) rtVal = wb_data;
    if (rs == '0) rsVal = '0;
    if (rt == '0) rtVal = '0;
    opAVal = rsVal;
    opBVal = isRType ? rtVal : {{(DATA_W-16){imm[15]}}, imm};
  end

  logic busyA;
  logic busyB;
  logic hazard;
  logic accept;

  assign hazard   = (busyA && !(wb_valid && (wb_reg == rs))) ||
                    (isRType && busyB && !(wb_valid && (wb_reg == rt)));
  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  reg_scoreboard #(.NREG(NREG)) uScoreboard (
    .clock    (clock),
    .reset_n  (reset_n),
    .clearAll (flush),
    .setEn    (accept && (dest != '0)),
    .setReg   (dest),
    .clrEn    (wb_valid),
    .clrReg   (wb_reg),
    .queryA   (rs),
    .queryB   (rt),
    .busyA    (busyA),
    .busyB    (busyB)
  );

  // Output bundle register; the payload only changes on an accept
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_funct <= '0;
      out_opA   <= '0;
      out_opB   <= '0;
      out_dest  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_op    <= op;
      out_funct <= funct;
      out_opA   <= opAVal;
      out_opB   <= opBVal;
      out_dest  <= dest;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
    end else if (in_valid && hazard && !flush && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: decode/bypass vector table, directed
// multi-cycle sequences, and randomized traffic against a reference model.
module tb_operand_fetch;

  logic        clock;
  logic        reset_n;
  logic        inValid;
  logic        inReady;
  logic [31:0] inInstr;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic        wbValid;
  logic [4:0]  wbReg;
  logic [31:0] wbData;
  logic        flushIn;
  logic        outValid;
  logic        outReady;
  logic [5:0]  outOp;
  logic [5:0]  outFunct;
  logic [31:0] outOpA;
  logic [31:0] outOpB;
  logic [4:0]  outDest;
  logic [15:0] stallCount;

  logic [31:0] regs [32];
  logic        useTable;
  logic [31:0] tRd1;
  logic [31:0] tRd2;

  int assertCount = 0;
  int failCount   = 0;

  assign readData1 = useTable ? tRd1 : regs[readReg1];
  assign readData2 = useTable ? tRd2 : regs[readReg2];

  operand_fetch dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (inValid),
    .in_ready    (inReady),
    .in_instr    (inInstr),
    .readReg1    (readReg1),
    .readReg2    (readReg2),
    .readData1   (readData1),
    .readData2   (readData2),
    .wb_valid    (wbValid),
    .wb_reg      (wbReg),
    .wb_data     (wbData),
    .flush       (flushIn),
    .out_valid   (outValid),
    .out_ready   (outReady),
    .out_op      (outOp),
    .out_funct   (outFunct),
    .out_opA     (outOpA),
    .out_opB     (outOpB),
    .out_dest    (outDest),
    .stall_count (stallCount)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        wbv;
    logic [4:0]  wbr;
    logic [31:0] wbd;
    logic [31:0] expA;
    logic [31:0] expB;
    logic [4:0]  expDest;
  } vecT;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic wv,
                               input logic [4:0] wr, input logic [31:0] wd,
                               input logic ordy, input logic fl);
    inValid  = v;
    inInstr  = instr;
    wbValid  = wv;
    wbReg    = wr;
    wbData   = wd;
    outReady = ordy;
    flushIn  = fl;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic resetDut();
    idle();
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
  endtask

  // Architectural value a source register should deliver this cycle
  function automatic logic [31:0] modelSrc(input logic [4:0] r, input logic wv,
                                           input logic [4:0] wr, input logic [31:0] wd);
    if (r == 5'd0) return 32'h0;
    if (wv && wr == r) return wd;
    return regs[r];
  endfunction

  vecT vecs [6];

  initial begin
    logic [31:0] mBusy;
    logic        mOutValid;
    logic [31:0] mA, mB, mInstr;
    logic [4:0]  mDest;
    int          mStall;

    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    useTable = 1'b0;
    tRd1 = 32'h0;
    tRd2 = 32'h0;
    idle();
    reset_n = 1'b0;

    vecs[0] = '{32'h00002820, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5};
    vecs[1] = '{32'h20438000, 32'h00000123, 32'h0, 1'b0, 5'd0, 32'h0, 32'h00000123, 32'hFFFF8000, 5'd3};
    vecs[2] = '{32'h20437FFF, 32'h00000456, 32'h0, 1'b0, 5'd0, 32'h0, 32'h00000456, 32'h00007FFF, 5'd3};
    vecs[3] = '{32'h00222020, 32'h0000AAAA, 32'h0000BBBB, 1'b1, 5'd1, 32'h11111111, 32'h11111111, 32'h0000BBBB, 5'd4};
    vecs[4] = '{32'h00013020, 32'hDEADBEEF, 32'h00001234, 1'b1, 5'd0, 32'h00000055, 32'h0, 32'h00001234, 5'd6};
    vecs[5] = '{32'h20E00001, 32'h00000777, 32'h0, 1'b0, 5'd0, 32'h0, 32'h00000777, 32'h00000001, 5'd0};

    // Reset state
    #12;
    checkOutput("rst_out_valid", {31'h0, outValid}, 32'h0);
    checkOutput("rst_out_opA", outOpA, 32'h0);
    checkOutput("rst_out_dest", {27'h0, outDest}, 32'h0);
    checkOutput("rst_stall", {16'h0, stallCount}, 32'h0);
    reset_n = 1'b1;
    tick();

    // ADDI r1=r0+5, then ADD r2=r1+r1 stalls until r1 is written back
    applyStimulus(1'b1, 32'h20010005, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    #1 checkOutput("addi_in_ready", {31'h0, inReady}, 32'h1);
    tick();
    checkOutput("addi_out_valid", {31'h0, outValid}, 32'h1);
    checkOutput("addi_opB", outOpB, 32'h5);
    checkOutput("addi_dest", {27'h0, outDest}, 32'h1);
    applyStimulus(1'b1, 32'h00211020, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    #1 checkOutput("add_stall_ready", {31'h0, inReady}, 32'h0);
    tick();
    checkOutput("add_stall_out_valid", {31'h0, outValid}, 32'h0);
    applyStimulus(1'b1, 32'h00211020, 1'b1, 5'd1, 32'h5, 1'b1, 1'b0);
    #1 checkOutput("add_wb_ready", {31'h0, inReady}, 32'h1);
    tick();
    regs[1] = 32'h5;
    checkOutput("add_opA", outOpA, 32'h5);
    checkOutput("add_opB", outOpB, 32'h5);
    checkOutput("add_dest", {27'h0, outDest}, 32'h2);
    checkOutput("add_stall_count", {16'h0, stallCount}, 32'h1);

    // Asynchronous reset pulse between edges with a bundle held
    idle();
    outReady = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("areset_out_valid", {31'h0, outValid}, 32'h0);
    checkOutput("areset_stall", {16'h0, stallCount}, 32'h0);
    checkOutput("areset_opA", outOpA, 32'h0);
    #1 reset_n = 1'b1;
    applyStimulus(1'b1, 32'h20010005, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    #1 checkOutput("post_reset_ready", {31'h0, inReady}, 32'h1);
    tick();
    checkOutput("post_reset_accept", {31'h0, outValid}, 32'h1);

    // Decode / bypass / sign-extension vector table, each from a clean scoreboard
    useTable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
      tick();
      tRd1 = vecs[i].rd1;
      tRd2 = vecs[i].rd2;
      applyStimulus(1'b1, vecs[i].instr, vecs[i].wbv, vecs[i].wbr, vecs[i].wbd, 1'b1, 1'b0);
      #1 checkOutput($sformatf("tbl%0d_in_ready", i), {31'h0, inReady}, 32'h1);
      tick();
      checkOutput($sformatf("tbl%0d_valid", i), {31'h0, outValid}, 32'h1);
      checkOutput($sformatf("tbl%0d_opA", i), outOpA, vecs[i].expA);
      checkOutput($sformatf("tbl%0d_opB", i), outOpB, vecs[i].expB);
      checkOutput($sformatf("tbl%0d_dest", i), {27'h0, outDest}, {27'h0, vecs[i].expDest});
      checkOutput($sformatf("tbl%0d_op", i), {26'h0, outOp}, {26'h0, vecs[i].instr[31:26]});
      checkOutput($sformatf("tbl%0d_funct", i), {26'h0, outFunct}, {26'h0, vecs[i].instr[5:0]});
    end

    // Backpressure: bundle held for 3 cycles, then the waiting instruction goes in
    applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    tick();
    tRd1 = 32'h100;
    tRd2 = 32'h200;
    applyStimulus(1'b1, 32'h00222020, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h20437FFF, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
      #1 checkOutput("bp_in_ready", {31'h0, inReady}, 32'h0);
      tick();
      checkOutput("bp_valid", {31'h0, outValid}, 32'h1);
      checkOutput("bp_opA", outOpA, 32'h100);
      checkOutput("bp_opB", outOpB, 32'h200);
      checkOutput("bp_dest", {27'h0, outDest}, 32'h4);
    end
    outReady = 1'b1;
    #1 checkOutput("bp_release_ready", {31'h0, inReady}, 32'h1);
    tick();
    checkOutput("bp_next_dest", {27'h0, outDest}, 32'h3);
    checkOutput("bp_next_opB", outOpB, 32'h00007FFF);

    // Flush clears the pending write to r3 so a reader of r3 issues without a stall
    applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h20430001, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("fl_issue_dest", {27'h0, outDest}, 32'h3);
    applyStimulus(1'b1, 32'h00632020, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
    #1 checkOutput("fl_in_ready", {31'h0, inReady}, 32'h0);
    tick();
    checkOutput("fl_out_valid", {31'h0, outValid}, 32'h0);
    applyStimulus(1'b1, 32'h00632020, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    #1 checkOutput("fl_r3_ready", {31'h0, inReady}, 32'h1);
    tick();
    checkOutput("fl_r3_valid", {31'h0, outValid}, 32'h1);
    checkOutput("fl_r3_dest", {27'h0, outDest}, 32'h4);
    checkOutput("fl_stall", {16'h0, stallCount}, 32'h0);

    // Randomized traffic against the reference model
    useTable = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    resetDut();
    mBusy = 32'h0;
    mOutValid = 1'b0;
    mA = 32'h0;
    mB = 32'h0;
    mInstr = 32'h0;
    mDest = 5'd0;
    mStall = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [31:0] instr;
      logic [4:0]  rs, rt, dst;
      logic        isR, wv, ordy, fl, v, hz, expRdy, acc;
      logic [4:0]  wr;
      logic [31:0] wd, valA, valB;
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      isR = ($urandom_range(0, 1) == 1);
      if (isR) instr = {6'd0, rs, rt, 5'($urandom_range(0, 3)), 5'($urandom), 6'($urandom)};
      else     instr = {6'd8, rs, rt, 16'($urandom)};
      dst  = isR ? instr[15:11] : rt;
      v    = ($urandom_range(0, 3) != 0);
      wv   = ($urandom_range(0, 2) == 0);
      wr   = 5'($urandom_range(0, 3));
      wd   = $urandom;
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      applyStimulus(v, instr, wv, wr, wd, ordy, fl);
      #1;
      hz = (mBusy[rs] && !(wv && wr == rs)) || (isR && mBusy[rt] && !(wv && wr == rt));
      expRdy = !fl && !hz && (!mOutValid || ordy);
      checkOutput("rnd_in_ready", {31'h0, inReady}, {31'h0, expRdy});
      valA = modelSrc(rs, wv, wr, wd);
      valB = isR ? modelSrc(rt, wv, wr, wd) : {{16{instr[15]}}, instr[15:0]};
      acc = v && expRdy;
      if (v && hz && !fl && mStall < 65535) mStall++;
      if (fl) begin
        mBusy = 32'h0;
        mOutValid = 1'b0;
      end else begin
        if (wv) mBusy[wr] = 1'b0;
        if (acc && dst != 5'd0) mBusy[dst] = 1'b1;
        if (acc) begin
          mOutValid = 1'b1;
          mA = valA;
          mB = valB;
          mInstr = instr;
          mDest = dst;
        end else if (ordy) begin
          mOutValid = 1'b0;
        end
      end
      tick();
      if (wv && wr != 5'd0) regs[wr] = wd;
      checkOutput("rnd_out_valid", {31'h0, outValid}, {31'h0, mOutValid});
      if (mOutValid) begin
        checkOutput("rnd_opA", outOpA, mA);
        checkOutput("rnd_opB", outOpB, mB);
        checkOutput("rnd_dest", {27'h0, outDest}, {27'h0, mDest});
        checkOutput("rnd_op", {26'h0, outOp}, {26'h0, mInstr[31:26]});
        checkOutput("rnd_funct", {26'h0, outFunct}, {26'h0, mInstr[5:0]});
      end
      checkOutput("rnd_stall", {16'h0, stallCount}, 32'(mStall));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter: DATA_W, 32, operand/data width.
REQ-002 Parameter: NREG, 32, architectural register count (index width 5).
REQ-003 Port: clock  in  1  single clock; all state updates on posedge.
REQ-004 Port: reset_n  in  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  in  1  upstream instruction valid.
REQ-006 Port: in_ready  out  1  stage accepts in_instr this cycle.
REQ-007 Port: in_instr  in  32  MIPS-format instruction.
REQ-008 Port: readReg1 / readReg2  out  5 each  register-file read addresses (rs / rt).
REQ-009 Port: readData1 / readData2  in  32 each  combinational register-file read data.
REQ-010 Port: wb_valid  in  1  register file is written this cycle.
REQ-011 Port: wb_reg  in  5  register being written.
REQ-012 Port: wb_data  in  32  value being written.
REQ-013 Port: flush  in  1  discard held instruction and clear all pending-write state.
REQ-014 Port: out_valid  out  1  operand bundle valid.
REQ-015 Port: out_ready  in  1  downstream accepts bundle.
REQ-016 Port: out_op  out  6  opcode; out_funct  out  6  funct field.
REQ-017 Port: out_opA / out_opB  out  32 each  operands; out_dest  out  5  destination (0 = none).
REQ-018 Port: stall_count  out  16  saturating count of hazard-stall cycles.

Function
REQ-019 Decode: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0], imm=[15:0]; readReg1=rs, readReg2=rt at all times.
REQ-020 R-type (op=0): opA=reg[rs], opB=reg[rt], dest=rd; otherwise opA=reg[rs], opB=sign-extended imm, dest=rt.
REQ-021 Source reg 0 reads as 0, regardless of readData or bypass.
REQ-022 Bypass: if wb_valid and wb_reg==source (nonzero), operand = wb_data, not readData.
REQ-023 Scoreboard: 32 busy bits; accepting an instruction with dest!=0 sets busy[dest]; wb_valid clears busy[wb_reg].
REQ-024 Same-cycle set and clear of one register: set wins.
REQ-025 Hazard = any used source busy and not cleared by wb this cycle (opB source is only used for R-type).
REQ-026 in_ready = !flush && !hazard && (!out_valid || out_ready).
REQ-027 Accept (in_valid && in_ready): output register loads the bundle next edge, out_valid=1; latency 1 cycle.
REQ-028 out_valid && !out_ready: all out_* held stable; no new accept.
REQ-029 out_valid && out_ready && no accept: out_valid=0 next edge.
REQ-030 stall_count increments on each cycle with in_valid && hazard && !flush; saturates at 0xFFFF.
REQ-031 flush: out_valid=0, all busy bits 0 next edge; instruction offered that cycle is not accepted; stall_count retained.

Reset
REQ-032 reset_n low asynchronously forces out_valid=0, all busy=0, out_op/out_funct/out_opA/out_opB/out_dest=0, stall_count=0.
REQ-033 Reset asserted mid-transaction discards the held bundle; first accept is possible on the first edge after reset_n rises.

Structure
REQ-034 Shared package holds opcode constants (R-type=0), instruction field bit positions, DATA_W, and register-index width.
REQ-035 Busy-bit array with set/clear/query ports is a sub-module named reg_scoreboard; the rest is flat.

Verification
REQ-036 ADDI r1 = r0+5 (0x20010005), then ADD r2 = r1+r1; wb r1=5 two cycles later -> ADD stalls until the wb cycle, issues with opA=opB=5 via bypass, stall_count=1.
REQ-037 R-type with rs=0, rt=0 and readData1/2=0xDEADBEEF -> out_opA=out_opB=0.
REQ-038 I-type imm=0x8000 -> out_opB=0xFFFF8000; imm=0x7FFF -> 0x00007FFF.
REQ-039 out_ready held low 3 cycles with out_valid=1 -> out_* stable, in_ready=0; release -> next instruction accepted in the same cycle.
REQ-040 Issue with dest=r3, then flush -> out_valid=0, busy[3]=0, a following read of r3 issues with no stall.
REQ-041 reset_n pulsed low asynchronously between edges with out_valid=1 -> out_valid=0 immediately, stall_count=0.
